// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide execution unit.
// Holds the funct3 encodings of the M-extension ops and the FSM state type.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/exec_muldiv_if.sv
// Issue/write-back bundle between the integer exec stage and exec_muldiv.
// master: exec stage side (drives flush, in_* op fields, out_ready).
// slave : the multiply/divide unit (drives in_ready, out_valid, out_rd, out_data).
interface exec_muldiv_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [RD_W-1:0] in_rd;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_rs1_v;
  logic [XLEN-1:0] in_rs2_v;
  logic            out_valid;
  logic            out_ready;
  logic [RD_W-1:0] out_rd;
  logic [XLEN-1:0] out_data;

  modport master (
    output flush, in_valid, in_rd, in_funct3, in_rs1_v, in_rs2_v, out_ready,
    input  in_ready, out_valid, out_rd, out_data
  );

  modport slave (
    input  flush, in_valid, in_rd, in_funct3, in_rs1_v, in_rs2_v, out_ready,
    output in_ready, out_valid, out_rd, out_data
  );
endinterface

// File: rtl/muldiv_div_iter.sv
// Radix-2 restoring divider datapath: one quotient bit per step.
// Ports: clk, rst_n (async active-low), load (capture unsigned dividend/divisor
// magnitudes), step (perform one restoring iteration), quot/rem (current registers).
// After XLEN steps quot/rem hold the unsigned quotient and remainder.
module muldiv_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);

  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN:0]   trial;

  // Shifted partial remainder minus divisor; the extra top bit is the borrow.
  // The partial remainder is always below the divisor, so XLEN+1 bits suffice.
  assign trial = {rem_q, quot_q[XLEN-1]} - {1'b0, dvs_q};

  always_comb begin
    quot_d = quot_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    if (load) begin
      quot_d = dividend;
      rem_d  = '0;
      dvs_d  = divisor;
    end else if (step) begin
      if (!trial[XLEN]) begin
        rem_d  = trial[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d  = {rem_q[XLEN-2:0], quot_q[XLEN-1]};
        quot_d = {quot_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;

endmodule

// File: rtl/exec_muldiv.sv
// RV32M/RV64M multiply/divide execution unit with valid/ready handshake.
// Ports: clk, rst_n (async active-low), bus (exec_muldiv_if.slave: issue side
// flush/in_valid/in_ready/in_rd/in_funct3/in_rs1_v/in_rs2_v, write-back side
// out_valid/out_ready/out_rd/out_data).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a new op
// MUL     | product settling for MUL_CYCLES edges
// DIV     | one restoring-divide step per edge, XLEN steps
// FIX     | apply quotient/remainder signs
// DONE    | result held on out_*, waiting for out_ready
module exec_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2,
  parameter int RD_W       = 5
) (
  input logic          clk,
  input logic          rst_n,
  exec_muldiv_if.slave bus
);

  localparam int CNT_MAX = (XLEN > MUL_CYCLES) ? XLEN : MUL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [2:0]      f3_q, f3_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            neg_q, neg_d;
  logic            out_valid_q, out_valid_d;
  logic [RD_W-1:0] out_rd_q, out_rd_d;
  logic [XLEN-1:0] out_data_q, out_data_d;

  logic            accept;
  logic            s1, s2, div_zero, div_ovf, special;
  logic [XLEN-1:0] mag1, mag2, special_res;
  logic            div_load, div_step;
  logic [XLEN-1:0] div_quot, div_rem, fix_src;
  logic            a_sgn, b_sgn;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  logic [XLEN-1:0] mul_res;

  assign accept = bus.in_valid && (state_q == ST_IDLE) && !bus.flush;

  // Signed ops (funct3[0]==0 for div/rem) divide magnitudes and fix signs later.
  assign s1   = !bus.in_funct3[0] && bus.in_rs1_v[XLEN-1];
  assign s2   = !bus.in_funct3[0] && bus.in_rs2_v[XLEN-1];
  assign mag1 = s1 ? -bus.in_rs1_v : bus.in_rs1_v;
  assign mag2 = s2 ? -bus.in_rs2_v : bus.in_rs2_v;

  assign div_zero    = (bus.in_rs2_v == '0);
  assign div_ovf     = !bus.in_funct3[0] && (bus.in_rs1_v == {1'b1, {(XLEN-1){1'b0}}})
                       && (bus.in_rs2_v == '1);
  assign special     = div_zero || div_ovf;
  assign special_res = div_zero ? (bus.in_funct3[1] ? bus.in_rs1_v : '1)
                                : (bus.in_funct3[1] ? '0 : bus.in_rs1_v);

  assign a_sgn   = (f3_q == F3_MULH) || (f3_q == F3_MULHSU);
  assign b_sgn   = (f3_q == F3_MULH);
  assign a_ext   = {{XLEN{a_sgn & op_a_q[XLEN-1]}}, op_a_q};
  assign b_ext   = {{XLEN{b_sgn & op_b_q[XLEN-1]}}, op_b_q};
  assign prod    = a_ext * b_ext;
  assign mul_res = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  assign fix_src = f3_q[1] ? div_rem : div_quot;

  muldiv_div_iter #(.XLEN(XLEN)) u_div_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load),
    .step     (div_step),
    .dividend (mag1),
    .divisor  (mag2),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    f3_d        = f3_q;
    rd_d        = rd_q;
    neg_d       = neg_q;
    out_valid_d = out_valid_q;
    out_rd_d    = out_rd_q;
    out_data_d  = out_data_q;
    div_load    = 1'b0;
    div_step    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        op_a_d = bus.in_rs1_v;
        op_b_d = bus.in_rs2_v;
        f3_d   = bus.in_funct3;
        rd_d   = bus.in_rd;
        // Remainder follows the dividend sign; quotient is negative if signs differ.
        neg_d  = bus.in_funct3[1] ? s1 : (s1 ^ s2);
        if (!bus.in_funct3[2]) begin
          state_d = ST_MUL;
          cnt_d   = CNT_W'(MUL_CYCLES - 1);
        end else if (special) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          out_rd_d    = bus.in_rd;
          out_data_d  = special_res;
        end else begin
          state_d  = ST_DIV;
          cnt_d    = CNT_W'(XLEN - 1);
          div_load = 1'b1;
        end
      end
      ST_MUL: if (cnt_q == '0) begin
        state_d     = ST_DONE;
        out_valid_d = 1'b1;
        out_rd_d    = rd_q;
        out_data_d  = mul_res;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      ST_DIV: begin
        div_step = 1'b1;
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_FIX: begin
        state_d     = ST_DONE;
        out_valid_d = 1'b1;
        out_rd_d    = rd_q;
        out_data_d  = neg_q ? -fix_src : fix_src;
      end
      ST_DONE: if (bus.out_ready) begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    // Redirect kills whatever is in flight, including a result waiting in DONE.
    if (bus.flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      div_load    = 1'b0;
      div_step    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      f3_q        <= '0;
      rd_q        <= '0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_rd_q    <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      f3_q        <= f3_d;
      rd_q        <= rd_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
      out_rd_q    <= out_rd_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_exec_muldiv.sv
module tb_exec_muldiv;
  localparam int XLEN       = 32;
  localparam int MUL_CYCLES = 2;
  localparam int RD_W       = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  exec_muldiv_if #(.XLEN(32), .RD_W(RD_W)) bus ();
  exec_muldiv_if #(.XLEN(64), .RD_W(RD_W)) bus64 ();

  exec_muldiv #(.XLEN(32), .MUL_CYCLES(MUL_CYCLES), .RD_W(RD_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  exec_muldiv #(.XLEN(64), .MUL_CYCLES(MUL_CYCLES), .RD_W(RD_W)) dut64 (
    .clk(clk), .rst_n(rst_n), .bus(bus64));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: RISC-V M semantics via wide plain arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p = '0;
    ref_op = '0;
    case (f3)
      3'd0: begin p = ua * ub; ref_op = p[31:0]; end
      3'd1: begin p = sa * sb; ref_op = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); ref_op = p[63:32]; end
      3'd3: begin p = ua * ub; ref_op = p[63:32]; end
      3'd4: if (b == 0) ref_op = 32'hFFFFFFFF;
            else begin q = sa / sb; p = q; ref_op = p[31:0]; end
      3'd5: if (b == 0) ref_op = 32'hFFFFFFFF;
            else begin p = ua / ub; ref_op = p[31:0]; end
      3'd6: if (b == 0) ref_op = a;
            else begin q = sa % sb; p = q; ref_op = p[31:0]; end
      default: if (b == 0) ref_op = a;
               else begin p = ua % ub; ref_op = p[31:0]; end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    if (!f3[2]) return MUL_CYCLES;
    if (b == 0) return 0;
    if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
    return XLEN + 1;
  endfunction

  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [RD_W-1:0] rd);
    bus.in_funct3 = f3;
    bus.in_rs1_v  = a;
    bus.in_rs2_v  = b;
    bus.in_rd     = rd;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [RD_W-1:0] rd, input logic [31:0] exp,
                        input int exp_lat, input string name);
    int lat;
    start_op(f3, a, b, rd);
    vectors++;
    if (bus.in_ready !== 1'b0 && exp_lat > 0) begin
      miscompares++;
      $display("FAIL %s busy_ready: got %b expected 0", name, bus.in_ready);
    end
    wait_valid(lat);
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s timeout: out_valid %b expected 1", name, bus.out_valid);
    end
    vectors++;
    if (lat != exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    vectors++;
    if (bus.out_data !== exp || bus.out_rd !== rd) begin
      miscompares++;
      $display("FAIL %s data: got %h rd %0d expected %h rd %0d", name, bus.out_data,
               bus.out_rd, exp, rd);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s release: in_ready %b out_valid %b expected 1 0", name,
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_rd !== '0 || bus.out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_out: valid %b rd %0d data %h expected 0 0 0", bus.out_valid,
               bus.out_rd, bus.out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    run_op(3'd0, 32'h7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 2, "mul_7x-3");
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 2, "mulhu_max");
    run_op(3'd1, 32'h80000000, 32'h80000000, 5'd3, 32'h40000000, 2, "mulh_min");
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFD, 33, "div_-7/2");
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFF, 33, "rem_-7/2");
    run_op(3'd5, 32'd100, 32'd7, 5'd6, 32'd14, 33, "divu_100/7");
    run_op(3'd7, 32'd100, 32'd7, 5'd7, 32'd2, 33, "remu_100/7");
    run_op(3'd5, 32'd5, 32'd0, 5'd8, 32'hFFFFFFFF, 0, "divu_5/0");
    run_op(3'd6, 32'd5, 32'd0, 5'd9, 32'd5, 0, "rem_5/0");
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 0, "div_ovf");
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'd0, 0, "rem_ovf");
  endtask

  task automatic test_random();
    logic [2:0] f3;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 20));
        default: ;
      endcase
      run_op(f3, a, b, RD_W'($urandom), ref_op(f3, a, b), ref_lat(f3, a, b), "random");
    end
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(3'd0, 32'h7, 32'hFFFFFFFD, 5'd21);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFFFFEB || bus.out_rd !== 5'd21
          || bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_%0d: valid %b data %h rd %0d ready %b expected 1 ffffffeb 21 0",
                 i, bus.out_valid, bus.out_data, bus.out_rd, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    #3;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_during_release: got %b expected 0", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release: ready %b valid %b expected 1 0", bus.in_ready,
               bus.out_valid);
    end
  endtask

  task automatic test_flush();
    bit seen;
    start_op(3'd5, 32'd100, 32'd7, 5'd12);
    repeat (10) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_div: valid %b ready %b expected 0 1", bus.out_valid, bus.in_ready);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL flush_no_result: out_valid seen 1 expected 0");
    end
    run_op(3'd5, 32'd9, 32'd3, 5'd13, 32'd3, 33, "divu_after_flush");

    // Flush together with an offer in IDLE: nothing accepted.
    bus.flush = 1'b1;
    start_op(3'd0, 32'd3, 32'd3, 5'd14);
    bus.flush = 1'b0;
    seen = (bus.in_ready !== 1'b1);
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL flush_idle: op accepted (ready %b valid %b) expected none",
               bus.in_ready, bus.out_valid);
    end

    // Flush and out_ready together in DONE.
    start_op(3'd0, 32'd6, 32'd7, 5'd15);
    repeat (MUL_CYCLES) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_done: valid %b ready %b expected 0 1", bus.out_valid,
               bus.in_ready);
    end
    run_op(3'd0, 32'd6, 32'd7, 5'd16, 32'd42, 2, "mul_after_flush");
  endtask

  task automatic test_reset_mid();
    bit seen;
    start_op(3'd0, 32'd3, 32'd5, 5'd9);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_rd !== '0 || bus.out_data !== '0
        || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid: valid %b rd %0d data %h ready %b expected 0 0 0 1",
               bus.out_valid, bus.out_rd, bus.out_data, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL reset_mid_result: out_valid seen 1 expected 0");
    end
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd17, 32'hFFFFFFFF, 2, "mulhsu_after_rst");
  endtask

  task automatic test_x64();
    int lat;
    bus64.in_funct3 = 3'd4;
    bus64.in_rs1_v  = 64'h8000000000000000;
    bus64.in_rs2_v  = '1;
    bus64.in_rd     = 5'd20;
    bus64.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus64.in_valid  = 1'b0;
    vectors++;
    if (bus64.out_valid !== 1'b1 || bus64.out_data !== 64'h8000000000000000) begin
      miscompares++;
      $display("FAIL x64_div_ovf: valid %b data %h expected 1 8000000000000000",
               bus64.out_valid, bus64.out_data);
    end
    bus64.out_ready = 1'b1;
    @(posedge clk); #1;
    bus64.out_ready = 1'b0;
    bus64.in_funct3 = 3'd6;
    bus64.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus64.in_valid  = 1'b0;
    vectors++;
    if (bus64.out_valid !== 1'b1 || bus64.out_data !== 64'd0) begin
      miscompares++;
      $display("FAIL x64_rem_ovf: valid %b data %h expected 1 0", bus64.out_valid,
               bus64.out_data);
    end
    bus64.out_ready = 1'b1;
    @(posedge clk); #1;
    bus64.out_ready = 1'b0;
    bus64.in_funct3 = 3'd4;
    bus64.in_rs1_v  = -64'sd1000;
    bus64.in_rs2_v  = 64'd7;
    bus64.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus64.in_valid  = 1'b0;
    lat = 0;
    while (bus64.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (lat != 65 || bus64.out_data !== 64'hFFFFFFFFFFFFFF72) begin
      miscompares++;
      $display("FAIL x64_div: lat %0d data %h expected 65 ffffffffffffff72", lat,
               bus64.out_data);
    end
    bus64.out_ready = 1'b1;
    @(posedge clk); #1;
    bus64.out_ready = 1'b0;
  endtask

  initial begin
    bus.flush = 1'b0;       bus.in_valid = 1'b0;   bus.out_ready = 1'b0;
    bus.in_rd = '0;         bus.in_funct3 = '0;
    bus.in_rs1_v = '0;      bus.in_rs2_v = '0;
    bus64.flush = 1'b0;     bus64.in_valid = 1'b0; bus64.out_ready = 1'b0;
    bus64.in_rd = '0;       bus64.in_funct3 = '0;
    bus64.in_rs1_v = '0;    bus64.in_rs2_v = '0;
    #12;
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_flush();
    test_reset_mid();
    test_x64();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
